// File: rtl/sw_token_router.sv
// Switch-stage input block: splits the SB token stream into a local loop-back FWFT queue and a
// network FWFT queue, absorbs memory-write tokens, and raises stall when either queue nears full.
module sw_token_router #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid_i_sw,
    input  logic        lr_i_sw,
    input  logic [15:0] node_i_sw,
    input  logic [11:0] gen_i_sw,
    input  logic [31:0] opr_i_sw,
    input  logic        pe_out_i_sw,
    input  logic [2:0]  pe_num_i_sw,
    input  logic        f_mem_w_i_sw,
    input  logic        uni_opr_i_sw,
    output logic        stall_o_sw,
    output logic        loc_valid_o_sw,
    input  logic        loc_ready_i_sw,
    output logic [61:0] loc_tok_o_sw,
    output logic        net_valid_o_sw,
    input  logic        net_ready_i_sw,
    output logic [64:0] net_tok_o_sw,
    output logic        ovf_o_sw,
    output logic [7:0]  drop_cnt_o_sw
);

    localparam logic [AW:0] CntFull  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CntStall = (AW+1)'(DEPTH - 1);

    logic [61:0]   loc_mem_q [DEPTH];
    logic [64:0]   net_mem_q [DEPTH];
    logic [AW-1:0] loc_wr_q, loc_rd_q, net_wr_q, net_rd_q;
    logic [AW:0]   loc_cnt_q, loc_cnt_d, net_cnt_q, net_cnt_d;
    logic          stall_q, ovf_q;
    logic [7:0]    drop_cnt_q;

    logic [61:0] loc_tok_in;
    logic [64:0] net_tok_in;
    logic        loc_req, net_req, loc_pop, net_pop, loc_push, net_push, drop;

    always_comb begin
        loc_tok_in = {lr_i_sw, node_i_sw, gen_i_sw, opr_i_sw, uni_opr_i_sw};
        net_tok_in = {pe_num_i_sw, loc_tok_in};
        // Memory-write tokens are consumed elsewhere, so they never reach either queue.
        loc_req  = tok_valid_i_sw & ~f_mem_w_i_sw & ~pe_out_i_sw;
        net_req  = tok_valid_i_sw & ~f_mem_w_i_sw & pe_out_i_sw;
        loc_pop  = loc_valid_o_sw & loc_ready_i_sw;
        net_pop  = net_valid_o_sw & net_ready_i_sw;
        loc_push = loc_req & ((loc_cnt_q != CntFull) | loc_pop);
        net_push = net_req & ((net_cnt_q != CntFull) | net_pop);
        drop     = (loc_req & ~loc_push) | (net_req & ~net_push);

        loc_cnt_d = loc_cnt_q;
        case ({loc_push, loc_pop})
            2'b10:   loc_cnt_d = loc_cnt_q + (AW+1)'(1);
            2'b01:   loc_cnt_d = loc_cnt_q - (AW+1)'(1);
            default: loc_cnt_d = loc_cnt_q;
        endcase
        net_cnt_d = net_cnt_q;
        case ({net_push, net_pop})
            2'b10:   net_cnt_d = net_cnt_q + (AW+1)'(1);
            2'b01:   net_cnt_d = net_cnt_q - (AW+1)'(1);
            default: net_cnt_d = net_cnt_q;
        endcase

        loc_valid_o_sw = (loc_cnt_q != '0);
        net_valid_o_sw = (net_cnt_q != '0);
        loc_tok_o_sw   = loc_valid_o_sw ? loc_mem_q[loc_rd_q] : '0;
        net_tok_o_sw   = net_valid_o_sw ? net_mem_q[net_rd_q] : '0;
        stall_o_sw     = stall_q;
        ovf_o_sw       = ovf_q;
        drop_cnt_o_sw  = drop_cnt_q;
    end

    // Storage needs no reset: heads are masked to zero while the queues are empty.
    always_ff @(posedge clk) begin
        if (loc_push) loc_mem_q[loc_wr_q] <= loc_tok_in;
        if (net_push) net_mem_q[net_wr_q] <= net_tok_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loc_wr_q   <= '0;
            loc_rd_q   <= '0;
            net_wr_q   <= '0;
            net_rd_q   <= '0;
            loc_cnt_q  <= '0;
            net_cnt_q  <= '0;
            stall_q    <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (loc_push) loc_wr_q <= loc_wr_q + AW'(1);
            if (loc_pop)  loc_rd_q <= loc_rd_q + AW'(1);
            if (net_push) net_wr_q <= net_wr_q + AW'(1);
            if (net_pop)  net_rd_q <= net_rd_q + AW'(1);
            loc_cnt_q <= loc_cnt_d;
            net_cnt_q <= net_cnt_d;
            // Threshold at DEPTH-1 leaves room for the token already in flight in SB.
            stall_q   <= (loc_cnt_d >= CntStall) | (net_cnt_d >= CntStall);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sw_token_router.sv
// Scoreboard bench for sw_token_router: directed stimulus pushes expected tokens, a negedge
// monitor pops and compares each handshake, and the main flow checks status outputs.
module tb_sw_token_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        tok_valid, lr, pe_out, f_mem_w, uni;
    logic [15:0] node;
    logic [11:0] gen;
    logic [31:0] opr;
    logic [2:0]  pe_num;
    logic        stall, loc_valid, loc_ready, net_valid, net_ready, ovf;
    logic [61:0] loc_tok;
    logic [64:0] net_tok;
    logic [7:0]  drop_cnt;

    logic [61:0] exp_loc[$];
    logic [64:0] exp_net[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    sw_token_router #(.DEPTH(4), .AW(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .tok_valid_i_sw (tok_valid),
        .lr_i_sw        (lr),
        .node_i_sw      (node),
        .gen_i_sw       (gen),
        .opr_i_sw       (opr),
        .pe_out_i_sw    (pe_out),
        .pe_num_i_sw    (pe_num),
        .f_mem_w_i_sw   (f_mem_w),
        .uni_opr_i_sw   (uni),
        .stall_o_sw     (stall),
        .loc_valid_o_sw (loc_valid),
        .loc_ready_i_sw (loc_ready),
        .loc_tok_o_sw   (loc_tok),
        .net_valid_o_sw (net_valid),
        .net_ready_i_sw (net_ready),
        .net_tok_o_sw   (net_tok),
        .ovf_o_sw       (ovf),
        .drop_cnt_o_sw  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Handshake completes on the following posedge, so negedge sees the token being popped.
    always @(negedge clk) begin
        if (loc_valid === 1'b1 && loc_ready === 1'b1) begin
            if (exp_loc.size() == 0) chk("loc_unexpected", {3'b0, loc_tok}, 65'h0 - 65'h1);
            else chk("loc_tok", {3'b0, loc_tok}, {3'b0, exp_loc.pop_front()});
        end
        if (net_valid === 1'b1 && net_ready === 1'b1) begin
            if (exp_net.size() == 0) chk("net_unexpected", net_tok, 65'h0 - 65'h1);
            else chk("net_tok", net_tok, exp_net.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 local, 1 network, 2 memory-write. accept=0 means the token is expected to drop.
    task automatic send(input int kind, input logic [2:0] pn, input logic [31:0] op,
                        input bit accept);
        tok_valid = 1'b1;
        lr        = op[0];
        node      = 16'h0042 + 16'(op[7:0]);
        gen       = 12'h3A0 + 12'(op[3:0]);
        opr       = op;
        uni       = op[1];
        pe_num    = pn;
        pe_out    = (kind != 0);
        f_mem_w   = (kind == 2);
        if (accept && kind == 0) exp_loc.push_back({lr, node, gen, opr, uni});
        if (accept && kind == 1) exp_net.push_back({pn, lr, node, gen, opr, uni});
        tick();
        tok_valid = 1'b0;
        f_mem_w   = 1'b0;
        pe_out    = 1'b0;
    endtask

    task automatic drain(input bit net);
        int i;
        if (net) net_ready = 1'b1;
        else loc_ready = 1'b1;
        for (i = 0; i < 20; i++) begin
            if ((net ? net_valid : loc_valid) == 1'b0) break;
            tick();
        end
        chk(net ? "net_drain_timeout" : "loc_drain_timeout", 65'(net ? net_valid : loc_valid),
            65'd0);
        net_ready = 1'b0;
        loc_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tok_valid = 1'b0; lr = 1'b0; pe_out = 1'b0; f_mem_w = 1'b0; uni = 1'b0;
        node = '0; gen = '0; opr = '0; pe_num = '0; loc_ready = 1'b0; net_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_stall", 65'(stall), 65'd0);
        chk("rst_loc_valid", 65'(loc_valid), 65'd0);
        chk("rst_net_valid", 65'(net_valid), 65'd0);
        chk("rst_loc_tok", 65'(loc_tok), 65'd0);
        chk("rst_net_tok", net_tok, 65'd0);
        chk("rst_ovf", 65'(ovf), 65'd0);
        chk("rst_drop_cnt", 65'(drop_cnt), 65'd0);

        // T1: single local token, hand-checked operand field
        send(0, 3'd0, 32'h1234_5678, 1'b1);
        chk("t1_loc_valid", 65'(loc_valid), 65'd1);
        chk("t1_opr_field", 65'(loc_tok[32:1]), 65'h1234_5678);
        chk("t1_node_field", 65'(loc_tok[60:45]), 65'h00BA);
        loc_ready = 1'b1;
        tick();
        loc_ready = 1'b0;
        chk("t1_loc_empty", 65'(loc_valid), 65'd0);
        chk("t1_loc_tok_zero", 65'(loc_tok), 65'd0);

        // T2: memory-write beats pe_out
        send(2, 3'd1, 32'hDEAD_0001, 1'b0);
        chk("t2_loc_valid", 65'(loc_valid), 65'd0);
        chk("t2_net_valid", 65'(net_valid), 65'd0);
        chk("t2_drop_cnt", 65'(drop_cnt), 65'd0);
        chk("t2_ovf", 65'(ovf), 65'd0);

        // T3: fill network queue, stall after third push, fifth drops
        for (int i = 0; i < 4; i++) begin
            send(1, 3'd5, 32'hA000_0010 + 32'(i), 1'b1);
            chk("t3_stall", 65'(stall), 65'(i >= 2));
        end
        chk("t3_pe_num_field", 65'(net_tok[64:62]), 65'd5);
        send(1, 3'd5, 32'hA000_00FF, 1'b0);
        chk("t3_ovf", 65'(ovf), 65'd1);
        chk("t3_drop_cnt", 65'(drop_cnt), 65'd1);
        drain(1'b1);
        chk("t3_stall_clear", 65'(stall), 65'd0);

        // T4: full local queue, push and pop together, then confirm it is still full
        for (int i = 0; i < 4; i++) send(0, 3'd0, 32'hB000_0020 + 32'(i), 1'b1);
        loc_ready = 1'b1;
        send(0, 3'd0, 32'hB000_0024, 1'b1);
        loc_ready = 1'b0;
        chk("t4_drop_none", 65'(drop_cnt), 65'd1);
        chk("t4_stall", 65'(stall), 65'd1);
        send(0, 3'd0, 32'hB000_0025, 1'b0);
        chk("t4_still_full", 65'(drop_cnt), 65'd2);
        drain(1'b0);

        // T5: interleaved traffic, only local drains
        loc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(0, 3'd0, 32'hC000_0030 + 32'(i), 1'b1);
            send(1, 3'(i + 2), 32'hC000_0040 + 32'(i), 1'b1);
        end
        chk("t5_loc_drained", 65'(loc_valid), 65'd0);
        chk("t5_net_held", 65'(net_valid), 65'd1);
        chk("t5_stall", 65'(stall), 65'd1);
        chk("t5_drop_cnt", 65'(drop_cnt), 65'd2);
        loc_ready = 1'b0;
        drain(1'b1);

        // T6: reset with both queues holding three entries
        for (int i = 0; i < 3; i++) begin
            send(0, 3'd0, 32'hD000_0050 + 32'(i), 1'b1);
            send(1, 3'd7, 32'hD000_0060 + 32'(i), 1'b1);
        end
        chk("t6_pre_stall", 65'(stall), 65'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_loc.delete();
        exp_net.delete();
        chk("t6_loc_valid", 65'(loc_valid), 65'd0);
        chk("t6_net_valid", 65'(net_valid), 65'd0);
        chk("t6_stall", 65'(stall), 65'd0);
        chk("t6_drop_cnt", 65'(drop_cnt), 65'd0);
        chk("t6_ovf", 65'(ovf), 65'd0);

        // Queue works normally after mid-operation reset
        send(1, 3'd3, 32'hE000_0070, 1'b1);
        chk("post_rst_net_valid", 65'(net_valid), 65'd1);
        drain(1'b1);

        chk("loc_sb_empty", 65'(exp_loc.size()), 65'd0);
        chk("net_sb_empty", 65'(exp_net.size()), 65'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
